// File: rtl/uart_tx_fifo_if.sv
// Host write bus plus transmitter handshake for the UART transmit FIFO.
interface uart_tx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              flush;
  logic              clr_ovf;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              idle;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  // Environment side: host plus the downstream transmitter
  modport master (
    output wr_en, wr_data, flush, clr_ovf, tx_busy,
    input  full, empty, level, overflow, idle, tx_start, tx_data
  );

  // FIFO side
  modport slave (
    input  wr_en, wr_data, flush, clr_ovf, tx_busy,
    output full, empty, level, overflow, idle, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter through a tx_start/tx_busy handshake.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned LVL_W = ADDR_W + 1;

  if ((DEPTH < 2) || (DEPTH != (32'd1 << ADDR_W))) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q;
  logic [7:0]         mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q;
  logic [ADDR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               overflow_q;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;

  logic full_c;
  logic empty_c;
  logic wr_ok_c;
  logic drop_c;
  logic pop_c;

  // Flags come from the registered level, so a same-cycle pop never rescues a write at full
  assign full_c  = (level_q == LVL_W'(DEPTH));
  assign empty_c = (level_q == '0);
  assign wr_ok_c = bus.wr_en && !full_c && !bus.flush;
  assign drop_c  = bus.wr_en &&  full_c && !bus.flush;
  assign pop_c   = (state_q == S_IDLE) && !empty_c && !bus.tx_busy && !bus.flush;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Pointers and fill level; flush drops everything queued by catching rd up to wr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok_c) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (bus.flush) begin
        rd_ptr_q <= wr_ptr_q;
        level_q  <= '0;
      end else begin
        if (pop_c) begin
          rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        end
        if (wr_ok_c && !pop_c) begin
          level_q <= level_q + LVL_W'(1);
        end else if (pop_c && !wr_ok_c) begin
          level_q <= level_q - LVL_W'(1);
        end
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop_c) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  // Launch FSM: pop head, hold request until the transmitter goes busy, then wait for it to finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_c) begin
            tx_data_q  <= mem[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (bus.tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.tx_busy) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.idle     = empty_c && (state_q == S_IDLE) && !bus.tx_busy;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter and a byte-order scoreboard.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];
  int         n_acc      = 0;
  int         tx_len     = 4;
  bit         force_busy = 1'b0;
  bit         xmt_hold   = 1'b0;
  logic       busy_m;
  int         cnt;

  assign bus.tx_busy = force_busy | busy_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: accepts tx_start when free, busy for tx_len cycles, checks byte order
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_m <= 1'b0;
      cnt    <= 0;
    end else if (busy_m) begin
      if (cnt == 0) busy_m <= 1'b0;
      else          cnt    <= cnt - 1;
    end else if (bus.tx_start && !force_busy && !xmt_hold) begin
      bit have;
      busy_m <= 1'b1;
      cnt    <= tx_len - 1;
      n_acc++;
      have = (sb.size() != 0);
      chk("launch_expected", 32'(have), 32'd1);
      if (have) chk("tx_data_order", 32'(bus.tx_data), 32'(sb.pop_front()));
    end
  end

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_start(input int maxc);
    int n = 0;
    while (bus.tx_start !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
    chk("tx_start_seen", 32'(bus.tx_start), 32'd1);
  endtask

  task automatic wait_busy(input logic v, input int maxc);
    int n = 0;
    while (bus.tx_busy !== v && n < maxc) begin @(negedge clk); n++; end
    chk("tx_busy_level", 32'(bus.tx_busy), 32'(v));
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (bus.idle !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
    chk("idle_reached", 32'(bus.idle), 32'd1);
  endtask

  initial begin
    int acc0;
    int gap;
    int sent;
    int guard;
    int maxl;

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush   = 1'b0;
    bus.clr_ovf = 1'b0;

    // Reset state
    #2;
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'h00);
    chk("rst_level",    32'(bus.level),    32'd0);
    chk("rst_empty",    32'(bus.empty),    32'd1);
    chk("rst_full",     32'(bus.full),     32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_idle",     32'(bus.idle),     32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte: latency of level, tx_start and the 2-cycle launch pulse
    sb.push_back(8'hA5);
    write_byte(8'hA5);
    chk("t1_level_n1",    32'(bus.level),    32'd1);
    chk("t1_start_n1",    32'(bus.tx_start), 32'd0);
    @(negedge clk);
    chk("t1_start_n2",    32'(bus.tx_start), 32'd1);
    chk("t1_data_n2",     32'(bus.tx_data),  32'hA5);
    @(negedge clk);
    chk("t1_busy_n3",     32'(bus.tx_busy),  32'd1);
    chk("t1_start_n3",    32'(bus.tx_start), 32'd1);
    chk("t1_level_n3",    32'(bus.level),    32'd0);
    @(negedge clk);
    chk("t1_start_n4",    32'(bus.tx_start), 32'd0);
    chk("t1_data_hold",   32'(bus.tx_data),  32'hA5);
    wait_idle(50);

    // Three queued bytes, slow transmitter: 2-clock inter-frame gap
    tx_len = 20;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(8'(i));
      write_byte(8'(i));
    end
    wait_start(10);
    wait_busy(1'b1, 10);
    for (int k = 2; k <= 3; k++) begin
      wait_busy(1'b0, 40);
      gap = 0;
      while (bus.tx_start !== 1'b1 && gap < 10) begin @(negedge clk); gap++; end
      chk("t2_gap", 32'(gap), 32'd2);
      chk("t2_data_at_start", 32'(bus.tx_data), 32'(k));
      wait_busy(1'b1, 10);
    end
    wait_busy(1'b0, 40);
    chk("t2_idle_in_done", 32'(bus.idle), 32'd0);
    @(negedge clk);
    chk("t2_idle_after",   32'(bus.idle), 32'd1);

    // Fill past full while transmitter is held busy
    tx_len     = 3;
    force_busy = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      if (i < int'(DEPTH)) sb.push_back(8'(8'h40 + i));
      write_byte(8'(8'h40 + i));
      if (i == int'(DEPTH) - 2) chk("t3_not_full_15", 32'(bus.full), 32'd0);
      if (i == int'(DEPTH) - 1) begin
        chk("t3_full_16",     32'(bus.full),     32'd1);
        chk("t3_no_ovf_16",   32'(bus.overflow), 32'd0);
      end
    end
    chk("t3_level_full", 32'(bus.level),    32'(DEPTH));
    chk("t3_overflow",   32'(bus.overflow), 32'd1);
    bus.clr_ovf = 1'b1;
    write_byte(8'hF0);
    bus.clr_ovf = 1'b0;
    chk("t3_set_beats_clr", 32'(bus.overflow), 32'd1);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    chk("t3_clr_ovf", 32'(bus.overflow), 32'd0);
    force_busy = 1'b0;
    write_byte(8'h99);
    chk("t3_drop_with_pop_ovf", 32'(bus.overflow), 32'd1);
    chk("t3_level_after_pop",   32'(bus.level),    32'(DEPTH - 1));
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    chk("t3_clr_ovf2", 32'(bus.overflow), 32'd0);
    wait_idle(400);

    // Pointer wrap: 40 sequential bytes through a 16-entry FIFO
    tx_len = 2;
    acc0   = n_acc;
    sent   = 0;
    guard  = 0;
    maxl   = 0;
    while (sent < 40 && guard < 2000) begin
      if (bus.full !== 1'b1) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'(sent);
        sb.push_back(8'(sent));
        sent++;
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
      guard++;
      if (int'(bus.level) > maxl) maxl = int'(bus.level);
    end
    bus.wr_en = 1'b0;
    wait_idle(1000);
    chk("t4_sent",        32'(sent),          32'd40);
    chk("t4_max_level",   32'(maxl),          32'(DEPTH));
    chk("t4_launches",    32'(n_acc - acc0),  32'd40);
    chk("t4_sb_drained",  32'(sb.size()),     32'd0);

    // Flush with 5 queued and one in flight, plus a concurrent write
    tx_len = 30;
    acc0   = n_acc;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(8'(8'h80 + i));
      write_byte(8'(8'h80 + i));
    end
    wait_busy(1'b1, 20);
    chk("t5_level_before", 32'(bus.level), 32'd5);
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    sb.delete();
    chk("t5_level_flushed", 32'(bus.level),    32'd0);
    chk("t5_empty_flushed", 32'(bus.empty),    32'd1);
    chk("t5_no_overflow",   32'(bus.overflow), 32'd0);
    chk("t5_inflight_busy", 32'(bus.tx_busy),  32'd1);
    wait_busy(1'b0, 40);
    repeat (8) @(negedge clk);
    chk("t5_one_launch",  32'(n_acc - acc0), 32'd1);
    chk("t5_no_start",    32'(bus.tx_start), 32'd0);
    chk("t5_idle",        32'(bus.idle),     32'd1);

    // Reset while a launch is pending on an unresponsive transmitter
    xmt_hold = 1'b1;
    sb.push_back(8'h5A);
    write_byte(8'h5A);
    wait_start(10);
    repeat (3) @(negedge clk);
    chk("t6_start_pending", 32'(bus.tx_start), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_start", 32'(bus.tx_start), 32'd0);
    chk("t6_rst_level", 32'(bus.level),    32'd0);
    chk("t6_rst_empty", 32'(bus.empty),    32'd1);
    sb.delete();
    @(negedge clk);
    rst      = 1'b0;
    xmt_hold = 1'b0;
    tx_len   = 4;
    @(negedge clk);
    sb.push_back(8'h3C);
    write_byte(8'h3C);
    wait_start(10);
    chk("t6_new_data", 32'(bus.tx_data), 32'h3C);
    wait_idle(50);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of the UART transmitter. Accepts bytes from the host over a one-cycle write strobe and stores them in a circular FIFO. Launches each byte into the transmitter via a `tx_start`/`tx_busy` handshake, so the host can queue a burst without polling `tx_busy` per byte. Reports full/empty, fill level and a sticky overflow flag.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `ADDR_W`, 4: pointer width; must equal log2(`DEPTH`).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe; one byte per cycle high.
- `wr_data`  in  8  byte to queue.
- `flush`  in  1  discards all queued bytes; the byte already launched is unaffected.
- `clr_ovf`  in  1  clears `overflow`.
- `full`  out  1  `level == DEPTH`.
- `empty`  out  1  `level == 0`.
- `level`  out  ADDR_W+1  number of queued bytes, 0..DEPTH.
- `overflow`  out  1  sticky; set by a dropped write.
- `idle`  out  1  `empty`, FSM in IDLE and `tx_busy` low.
- `tx_start`  out  1  launch request to the transmitter; registered.
- `tx_data`  out  8  byte presented to the transmitter; registered, held between launches.
- `tx_busy`  in  1  transmitter busy (high from the cycle after it accepts `tx_start` until its stop bit ends).

## Operation
- Storage: `DEPTH`×8 array with `rd_ptr` and `wr_ptr` (`ADDR_W` bits, wrap modulo `DEPTH`) and a registered count `level`.
- Write: `wr_en` with `full`=0 stores at `wr_ptr` and increments it.
- Dropped write: `wr_en` with `full`=1 drops the byte and sets `overflow`. `full` is the registered value, so the write is dropped even if a pop occurs in the same cycle.
- Level update: write only gives +1; pop only gives −1; write and pop together leave it unchanged.
- Flush: `flush`=1 zeroes `level` and sets `rd_ptr` to `wr_ptr`. A same-cycle `wr_en` is discarded and does not set `overflow`. The FSM state, `tx_data` and `tx_start` are unaffected.
- Overflow flag: `clr_ovf` clears `overflow`. If `clr_ovf` and a dropped write occur together, the set wins.
- FSM states:
  - IDLE: if `empty`=0 and `tx_busy`=0 (and no `flush` this cycle), pop the head: `tx_data`<=`mem[rd_ptr]`, `tx_start`<=1, go to LAUNCH.
  - LAUNCH: hold `tx_start`=1 until `tx_busy`=1 is sampled, then `tx_start`<=0 and go to DONE. There is no timeout; a transmitter held in reset keeps the request pending.
  - DONE: wait for `tx_busy`=0 sampled, then go to IDLE.
- Reset values: state IDLE, pointers 0, `level`=0, `empty`=1, `full`=0, `overflow`=0, `tx_start`=0, `tx_data`=0x00, `idle`=1 when `tx_busy`=0.
- Reset mid-operation: the queue and the byte in flight are abandoned. `tx_start` drops immediately (asynchronously).

## Timing
- Write latency: a write on cycle N is visible in `level`/`empty` at N+1. The earliest launch is `tx_start` high at N+2.
- Launch handshake: `tx_start` rises at N. The transmitter samples it at the end of N and `tx_busy` goes high at N+1. The FSM samples that at the end of N+1, so `tx_start` is low from N+2 (a 2-cycle pulse).
- `tx_data` is stable from the cycle `tx_start` rises through the next launch.
- Back-to-back: `tx_busy` is first low at M, the FSM is in IDLE at M+1, and the next `tx_start` rises at M+2. The inter-frame gap is 2 clocks.
- Pop and write at the same address when `level`=0: not possible. A pop requires `empty`=0 registered; the array is read-before-write.

## Test plan
- Reset then write 0xA5 at cycle 10 with `tx_busy` modelled: `level`=1 at 11, `tx_start`=1 at 12 with `tx_data`=0xA5, `tx_busy` rises at 13, `tx_start`=0 at 14, `level`=0 at 13.
- Queue 0x01,0x02,0x03 in consecutive cycles against a transmitter busy 20 cycles per byte: three launches in order, each `tx_start` 2 cycles after the previous `tx_busy` falls; `idle`=1 after the last.
- Hold `tx_busy`=1 and write DEPTH+2 bytes: `full`=1 after 16, last 2 dropped, `overflow`=1. Write with a simultaneous pop at full is also dropped. `clr_ovf` clears `overflow`.
- Pointer wrap: push and drain 40 sequential bytes 0x00..0x27 with `DEPTH`=16: output order is exact and `level` never exceeds 16.
- Flush with 5 queued while a byte is in flight, with concurrent `wr_en`: `level`=0 next cycle, the in-flight byte completes, no further launches, `overflow` stays 0.
- Assert `rst` while in LAUNCH: `tx_start`=0 in the same cycle, `level`=0, `empty`=1. After release, a new write launches normally.
